axi_mm_patchkr: RTL



---
 rtl/axi_mm_patchkr.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/axi_mm_patchkr.sv
// axi_mm_patchkr: pattern checker for the AXI-MM full examples.
// Buffers the generator's expected beats in a first-word-fall-through FIFO,
// accepts received beats over valid/ready and compares them one pipeline stage
// later. It accumulates beat/error counts, captures the first error and
// reports a pass/fail verdict.
module axi_mm_patchkr #(
  parameter int DATA_WIDTH = 128,
  parameter int CMP_WIDTH  = 128,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chkr_en,
  input  logic [7:0]            exp_cnt,
  input  logic [DATA_WIDTH-1:0] exp_din,
  input  logic                  exp_wr,
  output logic                  chkr_fifo_full,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_rdy,
  output logic [7:0]            rx_cnt,
  output logic [7:0]            err_cnt,
  output logic [7:0]            first_err_idx,
  output logic [CMP_WIDTH-1:0]  first_err_data,
  output logic                  exp_overflow,
  output logic                  done,
  output logic                  pass
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  // Two slots of margin absorb the generator's registered write enable.
  localparam logic [AW:0] FULL_MARK = (AW+1)'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_nxt;

  // Expected-data FIFO
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count, count_nxt;
  logic                  fifo_empty, fifo_full;
  logic                  push, pop, push_drop;

  // Run control
  logic                  en_q;
  logic                  start;
  logic                  at_limit;
  logic [7:0]            exp_cnt_q;

  // Compare pipeline stage
  logic                  cmp_vld;
  logic [CMP_WIDTH-1:0]  cmp_rx, cmp_exp;
  logic [7:0]            cmp_idx;
  logic                  cmp_last;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);

  // Once the final beat of a bounded run is accepted, rx_cnt equals exp_cnt
  // and no further beats are taken.
  assign at_limit = (exp_cnt_q != 8'd0) && (rx_cnt == exp_cnt_q);
  assign rx_rdy   = (state == S_RUN) && !fifo_empty && !at_limit;
  assign pop      = rx_valid && rx_rdy;

  // A pop in the same cycle frees a slot, so a push at full is still taken.
  assign push      = exp_wr && (!fifo_full || pop);
  assign push_drop = exp_wr && fifo_full && !pop;

  assign start    = (state == S_IDLE) && chkr_en && !en_q;
  assign cmp_last = cmp_vld && (exp_cnt_q != 8'd0) && (cmp_idx == exp_cnt_q - 8'd1);

  assign done = (state == S_DONE);
  assign pass = done && (err_cnt == 8'd0) && !exp_overflow;

  // Next FIFO occupancy from this cycle's push/pop.
  always_comb begin
    // NOTE: default assigned first so no path leaves count_nxt unassigned (no latch).
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
  end

  // FIFO storage; only written, never cleared.
  always_ff @(posedge clk) begin
    // NOTE: storage array is deliberately not reset; occupancy is tracked by pointers and count.
    if (push) mem[wr_ptr] <= exp_din;
  end

  // FIFO pointers, occupancy and registered almost-full flag.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      chkr_fifo_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count          <= count_nxt;
      chkr_fifo_full <= (count_nxt >= FULL_MARK);
    end
  end

  // Sticky overflow flag; a dropped push wins over the run-start clear.
  always_ff @(posedge clk) begin
    if (rst)            exp_overflow <= 1'b0;
    else if (push_drop) exp_overflow <= 1'b1;
    else if (start)     exp_overflow <= 1'b0;
  end

  // State register and enable edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      en_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      en_q  <= chkr_en;
    end
  end

  // Next-state logic; dropping the enable takes priority over completion.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (!chkr_en)      state_nxt = S_IDLE;
        else if (cmp_last) state_nxt = S_DONE;
      end
      S_DONE:  if (!chkr_en) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Acceptance counter, compare stage and error accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_cnt_q      <= 8'd0;
      rx_cnt         <= 8'd0;
      err_cnt        <= 8'd0;
      first_err_idx  <= 8'd0;
      first_err_data <= '0;
      cmp_vld        <= 1'b0;
      cmp_rx         <= '0;
      cmp_exp        <= '0;
      cmp_idx        <= 8'd0;
    end else if (start) begin
      exp_cnt_q      <= exp_cnt;
      rx_cnt         <= 8'd0;
      err_cnt        <= 8'd0;
      first_err_idx  <= 8'd0;
      first_err_data <= '0;
      cmp_vld        <= 1'b0;
    end else begin
      cmp_vld <= pop;
      if (pop) begin
        cmp_rx  <= rx_data[CMP_WIDTH-1:0];
        cmp_exp <= mem[rd_ptr][CMP_WIDTH-1:0];
        cmp_idx <= rx_cnt;
        rx_cnt  <= rx_cnt + 8'd1;
      end
      if (cmp_vld && (cmp_rx != cmp_exp)) begin
        // err_cnt saturates, so zero reliably marks "no error yet this run".
        if (err_cnt == 8'd0) begin
          first_err_idx  <= cmp_idx;
          first_err_data <= cmp_rx;
        end
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule
